com_bag_parse: RTL
==================

// Module: com_bag_parse
// PURPOSE
//  Command-packet parser sitting between the byte receiver (rx_data/rx_valid) and console.
//  Frames host bytes into packets, validates header, type and checksum, and presents
//  read_btype/read_bdata to console via the fs_com_read/fd_com_read handshake.
//  Only BAG_DIDX(4'h5), BAG_DPARAM(4'h6), BAG_DDIDX(4'h7) are forwarded; all else dropped and counted.
// PARAMETERS
//  HEAD0     8'h55      first header byte
//  HEAD1     8'hAA      second header byte
//  TOUT_CYC  16'd50000  inter-byte timeout in clk cycles while mid-packet; 0 disables timeout
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  rx_data      in   8  received byte, valid when rx_valid=1
//  rx_valid     in   1  one-cycle strobe per byte
//  fs_com_read  out  1  packet available (to console)
//  fd_com_read  in   1  console has taken the packet
//  read_btype   out  4  packet type, cmd[7:4]
//  read_bdata   out  4  packet data, cmd[3:0]
//  err_flag     out  1  one-cycle pulse on any drop event
//  err_cnt      out  8  saturating drop counter
// BEHAVIOUR
//  Reset: state=S_HEAD0, fs_com_read=0, read_btype=0, read_bdata=0, err_flag=0, err_cnt=0, tout cnt=0.
//  Packet: HEAD0, HEAD1, CMD, CHK, where CHK = ~CMD (8-bit bitwise invert).
//  States (8-bit codes): S_HEAD0=00, S_HEAD1=01, S_CMD=02, S_CHK=03, S_SEND=10, S_WAIT=11.
//  S_HEAD0: rx_valid & rx_data==HEAD0 -> S_HEAD1; other bytes ignored silently (no error).
//  S_HEAD1: byte==HEAD1 -> S_CMD; byte==HEAD0 -> stay S_HEAD1 (resync); else -> S_HEAD0, error.
//  S_CMD: any byte latched into cmd_tmp -> S_CHK.
//  S_CHK: byte==~cmd_tmp and cmd_tmp[7:4] in {5,6,7} -> S_SEND, read_btype/read_bdata <= cmd_tmp
//    at the same edge; bad checksum or unknown type -> S_HEAD0, error; outputs unchanged.
//  S_SEND: fs_com_read=1 (decoded from state). fd_com_read=1 -> S_WAIT.
//  S_WAIT: fs_com_read=0; fd_com_read=0 -> S_HEAD0. Console drops fd only after seeing fs low.
//  Latency: fs_com_read rises 1 cycle after the clk edge sampling the valid CHK byte.
//  read_btype/read_bdata stable from S_SEND entry until next valid packet; never change in S_SEND/S_WAIT.
//  rx_valid in S_SEND/S_WAIT: byte discarded, error (overrun); no framing progress.
//  Timeout: in S_HEAD1/S_CMD/S_CHK counter increments each cycle without rx_valid, clears on
//    rx_valid or state change; reaching TOUT_CYC -> S_HEAD0, error. Counter held 0 elsewhere.
//  Error: err_flag pulses 1 cycle (registered, cycle after event); err_cnt+1, saturates at 8'hFF.
//  Simultaneous timeout and rx_valid in same cycle: rx_valid wins, byte processed normally.
//  Reset mid-packet or mid-handshake: immediate return to reset values; fs_com_read drops at once.
// CONFIGURATION
//  COM_BAG_CHK_EN defined: 4-byte packet with CHK byte verified as above.
//  Undefined: 3-byte packet (HEAD0, HEAD1, CMD); S_CHK removed; type check done in S_CMD,
//    valid type -> S_SEND directly, unknown type -> S_HEAD0 with error. All other rules unchanged.
// TESTING
//  1 55 AA 65 9A, fd held 0 -> fs=1 next cycle, btype=6, bdata=5; fs stays 1; fd=1 -> fs=0; fd=0 -> S_HEAD0.
//  2 55 AA 65 9B -> no fs, err_flag pulse, err_cnt=1; then 55 AA 70 8F -> fs=1, btype=7, bdata=0.
//  3 55 55 AA 50 AF -> resync accepted, btype=5, bdata=0; 55 AA 30 CF -> dropped, err_cnt+1.
//  4 TOUT_CYC=16: 55 AA then 16 idle cycles -> S_HEAD0, err_cnt+1; next 55 AA 65 9A accepted.
//  5 during S_SEND feed 3 bytes -> err_cnt+3, read_btype/read_bdata unchanged; 300 errors -> err_cnt=FF.
//  6 assert rst after 55 AA 65 -> all outputs 0; 9A after release ignored; full packet then accepted.

Source files
------------

// File: rtl/com_bag_parse.sv
// -----------------------------------------------------------------------------
// com_bag_parse
//   Command-packet parser between the byte receiver and the console.
//   Frames host bytes into packets (HEAD0, HEAD1, CMD[, CHK]), validates the
//   header, the command type (5/6/7 only) and optionally the checksum
//   (CHK = ~CMD). It then presents the command nibbles to the console through
//   the fs_com_read/fd_com_read handshake. Every dropped byte or packet raises
//   a one-cycle err_flag pulse and bumps the saturating err_cnt.
//
//   Build option: define COM_BAG_CHK_EN for the 4-byte packet with a checksum
//   byte. When it is undefined, the packet is 3 bytes and the type is checked
//   on the CMD byte.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   rx_data[7:0] in   received byte, valid when rx_valid=1
//   rx_valid     in   one-cycle strobe per byte
//   fs_com_read  out  packet available to console
//   fd_com_read  in   console has taken the packet
//   read_btype   out  packet type, cmd[7:4]
//   read_bdata   out  packet data, cmd[3:0]
//   err_flag     out  one-cycle pulse after any drop event
//   err_cnt      out  saturating drop counter
// -----------------------------------------------------------------------------
module com_bag_parse #(
    parameter logic [7:0]  HEAD0    = 8'h55,
    parameter logic [7:0]  HEAD1    = 8'hAA,
    parameter logic [15:0] TOUT_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       fs_com_read,
    input  logic       fd_com_read,
    output logic [3:0] read_btype,
    output logic [3:0] read_bdata,
    output logic       err_flag,
    output logic [7:0] err_cnt
);

    typedef enum logic [7:0] {
        S_HEAD0 = 8'h00,
        S_HEAD1 = 8'h01,
        S_CMD   = 8'h02,
`ifdef COM_BAG_CHK_EN
        S_CHK   = 8'h03,
`endif
        S_SEND  = 8'h10,
        S_WAIT  = 8'h11
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tout_q, tout_d;
    logic        mid_pkt;
    logic        tout_hit;
    logic        err_evt;
    logic        load_out;
    logic [7:0]  load_val;
`ifdef COM_BAG_CHK_EN
    logic [7:0]  cmd_tmp_q, cmd_tmp_d;
`endif

    function automatic logic type_ok(input logic [3:0] t);
        return (t == 4'h5) || (t == 4'h6) || (t == 4'h7);
    endfunction

    // The inter-byte timeout only runs while a packet is partially received.
    always_comb begin
        mid_pkt = (state_q == S_HEAD1) || (state_q == S_CMD)
`ifdef COM_BAG_CHK_EN
                  || (state_q == S_CHK)
`endif
                  ;
    end

    // A byte arriving in the expiry cycle takes priority: the timeout needs !rx_valid.
    assign tout_hit = (TOUT_CYC != 16'd0) && mid_pkt && !rx_valid &&
                      (tout_q == TOUT_CYC - 16'd1);

    always_comb begin
        state_d  = state_q;
        err_evt  = 1'b0;
        load_out = 1'b0;
        load_val = rx_data;
`ifdef COM_BAG_CHK_EN
        cmd_tmp_d = cmd_tmp_q;
`endif
        case (state_q)
            S_HEAD0: begin
                if (rx_valid && rx_data == HEAD0)
                    state_d = S_HEAD1;
            end
            S_HEAD1: begin
                if (rx_valid) begin
                    if (rx_data == HEAD1) begin
                        state_d = S_CMD;
                    end else if (rx_data == HEAD0) begin
                        state_d = S_HEAD1;
                    end else begin
                        state_d = S_HEAD0;
                        err_evt = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (rx_valid) begin
`ifdef COM_BAG_CHK_EN
                    cmd_tmp_d = rx_data;
                    state_d   = S_CHK;
`else
                    if (type_ok(rx_data[7:4])) begin
                        load_out = 1'b1;
                        state_d  = S_SEND;
                    end else begin
                        state_d = S_HEAD0;
                        err_evt = 1'b1;
                    end
`endif
                end
            end
`ifdef COM_BAG_CHK_EN
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == ~cmd_tmp_q && type_ok(cmd_tmp_q[7:4])) begin
                        load_out = 1'b1;
                        load_val = cmd_tmp_q;
                        state_d  = S_SEND;
                    end else begin
                        state_d = S_HEAD0;
                        err_evt = 1'b1;
                    end
                end
            end
`endif
            S_SEND: begin
                // Bytes arriving while the console owns the packet are overruns.
                if (rx_valid)
                    err_evt = 1'b1;
                if (fd_com_read)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rx_valid)
                    err_evt = 1'b1;
                if (!fd_com_read)
                    state_d = S_HEAD0;
            end
            default: state_d = S_HEAD0;
        endcase

        if (tout_hit) begin
            state_d = S_HEAD0;
            err_evt = 1'b1;
        end
    end

    // Count idle cycles in a partial packet; any byte or state change restarts it.
    always_comb begin
        if (TOUT_CYC != 16'd0 && mid_pkt && !rx_valid && state_d == state_q)
            tout_d = tout_q + 16'd1;
        else
            tout_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HEAD0;
            tout_q     <= '0;
            read_btype <= '0;
            read_bdata <= '0;
            err_flag   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state_q  <= state_d;
            tout_q   <= tout_d;
            err_flag <= err_evt;
            if (err_evt && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (load_out) begin
                read_btype <= load_val[7:4];
                read_bdata <= load_val[3:0];
            end
        end
    end

`ifdef COM_BAG_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmd_tmp_q <= '0;
        else
            cmd_tmp_q <= cmd_tmp_d;
    end
`endif

    assign fs_com_read = (state_q == S_SEND);

endmodule
